// File: rtl/sram_slot_arbiter_pkg.sv
// Shared types for the expansion-board SRAM slot arbiter.
package gbx_slot_pkg;

  // Position of the board clock inside one Gigatron clock period
  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  // Owner of the current aux window
  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    DMA  = 2'd2
  } grant_t;

  // Aux windows a pending DMA request may lose to video in a row
  localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/sram_slot_arbiter_clk_phase_lock.sv
// Synchronises the Gigatron clock, tracks the 4-phase position of the board
// clock within it and reports whether the tracker is in step.
module clk_phase_lock
  import gbx_slot_pkg::*;
(
  input  logic   CLKx4,
  input  logic   nRESET,
  input  logic   CLK,
  output phase_t phase,
  output phase_t phase_nxt,
  output logic   locked,
  output logic   locked_nxt
);

  logic s1, s2, s3;
  logic good, good_nxt;
  logic rise, slip;

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= CLK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Next phase and lock state; the top uses these to register its outputs
  // in step with the phase they belong to
  always_comb begin
    rise       = s2 & ~s3;
    slip       = rise && (phase != P3);
    phase_nxt  = rise ? P0 : phase_t'(phase + 2'd1);
    locked_nxt = locked;
    good_nxt   = good;
    if (slip) begin
      locked_nxt = 1'b0;
      good_nxt   = 1'b0;
    end else if (rise) begin
      if (good) locked_nxt = 1'b1;
      good_nxt = 1'b1;
    end
  end

  // Phase counter and lock detector state
  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      phase  <= P0;
      locked <= 1'b0;
      good   <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      locked <= locked_nxt;
      good   <= good_nxt;
    end
  end

endmodule

// File: rtl/sram_slot_arbiter.sv
// Shares the expansion SRAM between the Gigatron bus (P0/P1) and an aux
// window (P2/P3) arbitrated between video prefetch and a DMA port, with a
// bounded starvation limit for DMA.
module sram_slot_arbiter
  import gbx_slot_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned AW         = 19
) (
  input  logic          CLKx4,
  input  logic          nRESET,
  input  logic          CLK,
  input  logic          vreq,
  input  logic [AW-1:0] vaddr,
  output logic          vack,
  output logic [7:0]    vdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [7:0]    dma_rdata,
  input  logic [7:0]    RD,
  output logic          nAE,
  output logic [AW-1:0] ra,
  output logic          aux_nwe,
  output logic [7:0]    aux_dout,
  output logic          aux_doe,
  output logic          locked
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  phase_t        phase, phase_nxt;
  logic          locked_nxt;
  grant_t        gnt, gnt_nxt;
  logic          we_q, we_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic          start, done, vwin, dwin;

  clk_phase_lock u_lock (
    .CLKx4      (CLKx4),
    .nRESET     (nRESET),
    .CLK        (CLK),
    .phase      (phase),
    .phase_nxt  (phase_nxt),
    .locked     (locked),
    .locked_nxt (locked_nxt)
  );

  // Arbitration at P1->P2; a grant survives only while the window runs
  // locked into P3, so a lock loss drops it on the very next edge
  always_comb begin
    start      = locked_nxt && (phase_nxt == P2);
    done       = locked_nxt && (phase == P3) && (phase_nxt == P0) && (gnt != NONE);
    vwin       = vreq && (!dma_req || (starve < SW'(STARVE_MAX)));
    dwin       = !vwin && dma_req;
    gnt_nxt    = NONE;
    we_nxt     = we_q;
    starve_nxt = starve;
    if (start) begin
      if (vwin) begin
        gnt_nxt = VID;
      end else if (dwin) begin
        gnt_nxt = DMA;
        we_nxt  = dma_we;
      end
      if (dwin || !dma_req) starve_nxt = '0;
      else if (starve != SW'(STARVE_MAX)) starve_nxt = starve + SW'(1);
    end else begin
      if (locked_nxt && (phase_nxt == P3)) gnt_nxt = gnt;
      if (!dma_req) starve_nxt = '0;
    end
  end

  // Registered SRAM controls, latched address/data and completion acks
  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      gnt       <= NONE;
      we_q      <= 1'b0;
      starve    <= '0;
      nAE       <= 1'b0;
      ra        <= '0;
      aux_nwe   <= 1'b1;
      aux_doe   <= 1'b0;
      aux_dout  <= '0;
      vack      <= 1'b0;
      dma_ack   <= 1'b0;
      vdata     <= '0;
      dma_rdata <= '0;
    end else begin
      gnt     <= gnt_nxt;
      we_q    <= we_nxt;
      starve  <= starve_nxt;
      nAE     <= locked_nxt && ((phase_nxt == P2) || (phase_nxt == P3));
      aux_doe <= (gnt_nxt == DMA) && we_nxt;
      aux_nwe <= !((gnt_nxt == DMA) && we_nxt && (phase_nxt == P3));
      vack    <= done && (gnt == VID);
      dma_ack <= done && (gnt == DMA);
      if (start && vwin) begin
        ra <= vaddr;
      end else if (start && dwin) begin
        ra <= dma_addr;
        if (dma_we) aux_dout <= dma_wdata;
      end
      if (done && (gnt == VID)) vdata <= RD;
      if (done && (gnt == DMA) && !we_q) dma_rdata <= RD;
    end
  end

endmodule

// File: doc/sram_slot_arbiter.md
# sram_slot_arbiter

Sequences the expansion board's shared SRAM between the Gigatron bus and two auxiliary requesters: the video prefetch engine and a generic DMA port (SPI block transfer, future blitter). It runs on the fast board clock, phase-locks to the Gigatron clock, and splits each Gigatron cycle into a Gigatron window and an aux window. Within the aux window it arbitrates video against DMA, with a bounded starvation guarantee for DMA. It drives the address latch select, the aux SRAM address, and the aux write strobe.

## Interface
- `STARVE_MAX`, 3: maximum consecutive aux windows a pending DMA request can lose to video.
- `AW`, 19: SRAM address width.

- `CLKx4`  in  1  board clock, 4× the Gigatron clock; all logic on its rising edge.
- `nRESET`  in  1  asynchronous, active-low reset.
- `CLK`  in  1  Gigatron clock level; sampled and not used as a clock.
- `vreq`  in  1  video wants a pixel fetch (level).
- `vaddr`  in  AW  video fetch address.
- `vack`  out  1  one-cycle pulse; `vdata` valid.
- `vdata`  out  8  video read data.
- `dma_req`  in  1  DMA request; hold stable with `dma_we`, `dma_addr`, `dma_wdata` until `dma_ack`.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_addr`  in  AW  DMA address.
- `dma_wdata`  in  8  DMA write data.
- `dma_ack`  out  1  one-cycle completion pulse.
- `dma_rdata`  out  8  read data, valid with `dma_ack`.
- `RD`  in  8  SRAM data in.
- `nAE`  out  1  0 = Gigatron owns the SRAM address; 1 = aux window.
- `ra`  out  AW  aux address, meaningful while `nAE`=1.
- `aux_nwe`  out  1  active-low aux write strobe.
- `aux_dout`  out  8  aux write data.
- `aux_doe`  out  1  drive `aux_dout` onto the SRAM data bus.
- `locked`  out  1  phase tracker is synchronised.

## Operation
- Two-stage synchroniser on `CLK`. A rising edge is detected when the synchronised value goes 0→1.
- Phase counter P0..P3 advances by 1 mod 4 each cycle. On a detected rising edge it is forced to P0.
- If a rising edge is detected when the counter would not naturally reach P0:
  - clear `locked`;
  - `locked` sets again after two consecutive edges that each land on the natural P0.
- P0, P1: Gigatron window, `nAE`=0.
- P2, P3: aux window, `nAE`=1, but only when `locked`=1. While unlocked, `nAE` stays 0 and no grants are made.
- Arbitration is evaluated at the P1→P2 edge, using `vreq`/`dma_req` as sampled on that edge:
  - Video wins if `vreq`=1 and (`dma_req`=0 or `starve` < `STARVE_MAX`).
  - Otherwise DMA wins if `dma_req`=1.
  - Otherwise the window is idle.
- `starve` (width clog2(STARVE_MAX+1)):
  - increments, saturating, when DMA is pending and loses;
  - clears when DMA is granted or `dma_req`=0.
- The address of the granted requester is latched into `ra` at P1→P2 and held through P3.
- DMA write:
  - `aux_doe`=1 during P2..P3;
  - `aux_nwe`=0 during P3 only, so the address is stable for one cycle before and after the strobe.
- Reads: `RD` is captured at the P3→P0 edge into `vdata` or `dma_rdata`. The matching ack pulses during P0.
- DMA write ack also pulses in P0.
- At most one ack per Gigatron cycle.

## Timing
- Reset values: `nAE`=0, `ra`=0, `aux_nwe`=1, `aux_doe`=0, `aux_dout`=0, `vack`=0, `dma_ack`=0, `vdata`=0, `dma_rdata`=0, `locked`=0, phase=P0, `starve`=0.
- Latency: a request sampled at P1→P2 is acked in the following P0, 3 cycles later. Worst-case DMA wait is (`STARVE_MAX`+1) Gigatron cycles after lock.
- `dma_req` may drop in the ack cycle or be held to chain the next transfer. The next transfer is sampled at the next P1→P2.
- Dropping `dma_req` before a grant is allowed and has no effect. Dropping it after a grant is a protocol violation; the transfer completes regardless.
- Loss of lock during P2/P3: the current window is aborted. `nAE`, `aux_nwe` and `aux_doe` return to their reset levels on the next edge and no ack is issued. The requester keeps `dma_req` high and is retried.
- Asynchronous reset mid-window: `aux_nwe` deasserts immediately and the transfer is dropped without an ack.
- `aux_nwe` is never 0 while `nAE`=0.

## Structure
- Package `gbx_slot_pkg` holds:
  - the phase enum P0..P3;
  - the grant enum NONE/VID/DMA;
  - the default `STARVE_MAX`.
- Sub-module `clk_phase_lock`: `CLK` synchroniser, phase counter, lock detector. Outputs phase and `locked`.

## Test plan
- Steady `CLK` at ¼ rate, no requests → `locked`=1 after 2 edges; `nAE` high exactly in P2/P3; no acks.
- DMA read from `dma_addr`=0x12345, `RD`=0xA5 → `ra`=0x12345 in P2..P3; `dma_ack` in next P0 with `dma_rdata`=0xA5.
- DMA write of 0x3C to 0x00100 → `aux_doe` high in P2..P3; `aux_nwe` low only in P3; `aux_dout`=0x3C; ack in P0.
- `vreq` and `dma_req` held high, `STARVE_MAX`=3 → grants repeat VID, VID, VID, DMA; `starve` returns to 0.
- Inject an early `CLK` edge at P2 during a DMA write → `aux_nwe` stays 1; no ack; `locked`=0; DMA completes after re-lock.
- Assert `nRESET` during P3 of a write → `aux_nwe`=1 immediately; all outputs at reset values.
